// File: rtl/cksum.sv
// cksum: Ethernet FCS checker for a 2-bit RMII receive stream.
// Runs a CRC-32 over each frame and flags FCS mismatches when valid drops.
module cksum (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] axiid,
    input  logic       axiiv,
    output logic       done,
    output logic       kill
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [31:0] POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] RESIDUE = 32'hC704_DD7B;
    state_t      state_q;
    logic [31:0] crc_q, crc_d, crc_mid;
    logic        done_q, kill_q;
    function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b);
        return {c[30:0], 1'b0} ^ ((c[31] ^ b) ? POLY : 32'h0);
    endfunction
    // a frame's first dibit is folded into a fresh init value, not the stale register
    always_comb begin
        crc_mid = crc_bit(state_q == RUN ? crc_q : INIT, axiid[0]);
        crc_d   = crc_bit(crc_mid, axiid[1]);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            crc_q   <= INIT;
            done_q  <= 1'b0;
            kill_q  <= 1'b0;
        end else if (axiiv) begin
            state_q <= RUN;
            crc_q   <= crc_d;
            if (state_q != RUN) begin
                done_q <= 1'b0;
                kill_q <= 1'b0;
            end
        end else if (state_q == RUN) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            kill_q  <= crc_q != RESIDUE;
        end
    end
    assign done = done_q;
    assign kill = kill_q;
endmodule

// File: tb/tb_cksum.sv
// tb_cksum: directed checks of the cksum FCS checker.
module tb_cksum;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] axiid = 2'b00;
    logic       axiiv = 1'b0;
    logic       done, kill;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] fb [0:15];

    cksum dut (.clk(clk), .rst(rst), .axiid(axiid), .axiiv(axiiv), .done(done), .kill(kill));

    always #5 clk = ~clk;

    task automatic load_good();
        logic [7:0] g [0:12];
        g = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
              8'h26, 8'h39, 8'hF4, 8'hCB};
        for (int i = 0; i < 13; i++) fb[i] = g[i];
    endtask

    task automatic load_corrupt();
        for (int i = 0; i < 5; i++) fb[i] = 8'hE4;
    endtask

    task automatic send_frame(input int n, input logic chk_clear, input string name);
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                axiiv = 1'b1;
                axiid = fb[i][2*k +: 2];
                if (chk_clear && i == 0 && k == 0) begin
                    @(posedge clk); #1;
                    n_checks++;
                    if (done !== 1'b0 || kill !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s clear: done=%b kill=%b required done=0 kill=0", name, done, kill);
                    end
                end
            end
    endtask

    task automatic end_frame(input logic exp_kill, input string name);
        @(negedge clk);
        axiiv = 1'b0;
        axiid = 2'b11;
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b1 || kill !== exp_kill) begin
            n_fail++;
            $display("FAIL %s end: done=%b kill=%b required done=1 kill=%b", name, done, kill, exp_kill);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            n_checks++;
            if (done !== 1'b0 || kill !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle: done=%b kill=%b required done=0 kill=0", done, kill);
            end
        end
    endtask

    task automatic test_corrupt();
        load_corrupt();
        send_frame(5, 1'b1, "corrupt");
        end_frame(1'b1, "corrupt");
        repeat (4) begin
            @(posedge clk); #1;
            n_checks++;
            if (done !== 1'b1 || kill !== 1'b1) begin
                n_fail++;
                $display("FAIL corrupt_hold: done=%b kill=%b required done=1 kill=1", done, kill);
            end
        end
    endtask

    task automatic test_good();
        load_good();
        send_frame(13, 1'b1, "good");
        end_frame(1'b0, "good");
        repeat (2) @(negedge clk);
        load_good();
        fb[0] = 8'h30;
        send_frame(13, 1'b1, "flip_lsb");
        end_frame(1'b1, "flip_lsb");
        repeat (2) @(negedge clk);
        load_good();
        fb[11] = 8'h74;
        send_frame(13, 1'b0, "flip_fcs");
        end_frame(1'b1, "flip_fcs");
    endtask

    task automatic test_back_to_back();
        load_corrupt();
        send_frame(5, 1'b0, "b2b1");
        end_frame(1'b1, "b2b1");
        load_good();
        send_frame(13, 1'b1, "b2b2");
        end_frame(1'b0, "b2b2");
    endtask

    task automatic test_reset_in_done();
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (done !== 1'b0 || kill !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done_async: done=%b kill=%b required done=0 kill=0", done, kill);
        end
        #1 rst = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        load_corrupt();
        send_frame(5, 1'b0, "pre");
        end_frame(1'b1, "pre");
        for (int i = 0; i < 61; i++) begin
            @(negedge clk);
            axiiv = 1'b1;
            axiid = 2'b01;
            if (i == 29) begin
                @(posedge clk); #1;
                rst = 1'b0;
                #1;
                n_checks++;
                if (done !== 1'b0 || kill !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_mid: done=%b kill=%b required done=0 kill=0", done, kill);
                end
                #1 rst = 1'b1;
            end
        end
        end_frame(1'b1, "post_reset");
    endtask

    task automatic test_single_dibit();
        @(negedge clk);
        axiiv = 1'b1;
        axiid = 2'b01;
        end_frame(1'b1, "single");
    endtask

    initial begin
        test_reset();
        test_corrupt();
        test_good();
        test_back_to_back();
        test_reset_in_done();
        test_reset_mid_frame();
        test_single_dibit();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
